// File: rtl/packet_pkg.sv
// Shared switch packet definitions: widths, packet classification and tx FSM states.
package packet_pkg;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {SDP, MDP, BDP, ERR} p_type;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] data;
  } tx_req_t;

  function automatic logic [2:0] pop_cnt(logic [ADDR_WIDTH-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) c = c + 3'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/packet_tx_if.sv
// Host request and switch ingress handshake bundle for one port's transmitter.
interface packet_tx_if;
  import packet_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_target;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_source;
  logic [ADDR_WIDTH-1:0] out_target;
  logic [DATA_WIDTH-1:0] out_data;
  p_type                 out_type;

  modport master (
    input  req_valid, req_target, req_data, out_ready,
    output req_ready, out_valid, out_source, out_target, out_data, out_type
  );

  modport slave (
    output req_valid, req_target, req_data, out_ready,
    input  req_ready, out_valid, out_source, out_target, out_data, out_type
  );
endinterface

// File: rtl/packet_parser.sv
// Combinational packet classifier/validator, shared by the rx parser and tx stamping.
module packet_parser
  import packet_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] source,
  input  logic [ADDR_WIDTH-1:0] target,
  output p_type                 ptype,
  output logic                  valid
);
  always_comb begin
    ptype = ERR;
    case (pop_cnt(target))
      3'd0:        ptype = ERR;
      3'd1:        ptype = SDP;
      3'd2, 3'd3:  ptype = MDP;
      default:     ptype = BDP;
    endcase
    // broadcast is the only class allowed to include the sender itself
    valid = (ptype != ERR) && (((target & source) == '0) || (ptype == BDP));
  end
endmodule

// File: rtl/packet_tx.sv
// Per-port transmitter: latch host request, stamp source, classify, send or drop, with stall abort.
module packet_tx
  import packet_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  packet_tx_if.master bus,
  output logic        err_drop,
  output logic        timeout,
  output logic [15:0] sent_cnt,
  output logic [7:0]  err_cnt
);
  localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] SRC = ADDR_WIDTH'(1 << PORT_ID);

  tx_state_t     state, state_nxt;
  tx_req_t       pkt_q;
  p_type         type_q;
  p_type         req_type;
  logic          req_ok;
  logic [SW-1:0] stall_q;
  logic          accept, drop, xfer, abort;

  packet_parser u_parser (
    .source (SRC),
    .target (bus.req_target),
    .ptype  (req_type),
    .valid  (req_ok)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    xfer      = 1'b0;
    abort     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (bus.req_valid) begin
          if (req_ok) begin
            accept    = 1'b1;
            state_nxt = TX_SEND;
          end else begin
            drop = 1'b1;
          end
        end
      end
      TX_SEND: begin
        // a ready arriving on the last stall cycle still delivers
        if (bus.out_ready) begin
          xfer      = 1'b1;
          state_nxt = TX_IDLE;
        end else if (stall_q == STALL_MAX) begin
          abort     = 1'b1;
          state_nxt = TX_IDLE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q    <= '0;
      type_q   <= ERR;
      stall_q  <= '0;
      err_drop <= 1'b0;
      timeout  <= 1'b0;
      sent_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      err_drop <= drop;
      timeout  <= abort;
      if (accept) begin
        pkt_q  <= '{target: bus.req_target, data: bus.req_data};
        type_q <= req_type;
      end
      if (accept || state_nxt != TX_SEND) stall_q <= '0;
      else if (!bus.out_ready)            stall_q <= stall_q + 1'b1;
      if (xfer) sent_cnt <= sent_cnt + 16'd1;
      if ((drop || abort) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.req_ready  = (state == TX_IDLE);
  assign bus.out_valid  = (state == TX_SEND);
  assign bus.out_source = SRC;
  assign bus.out_target = pkt_q.target;
  assign bus.out_data   = pkt_q.data;
  assign bus.out_type   = type_q;
endmodule

// File: tb/tb_packet_tx.sv
// Directed bench for packet_tx with a scoreboard of expected deliveries.
module tb_packet_tx;
  import packet_pkg::*;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] data;
    p_type                 ptype;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_drop, timeout;
  logic [15:0] sent_cnt;
  logic [7:0]  err_cnt;
  int          errors = 0;
  int          checks = 0;
  int          n_xfer = 0;
  exp_t        sb[$];

  packet_tx_if bus ();

  packet_tx #(.PORT_ID(0), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_drop (err_drop),
    .timeout  (timeout),
    .sent_cnt (sent_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] t, input logic [7:0] d);
    bus.req_valid  = 1'b1;
    bus.req_target = t;
    bus.req_data   = d;
  endtask

  // A transfer happens at the next posedge whenever valid&&ready hold at the negedge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_t e;
      n_xfer++;
      if (sb.size() == 0) begin
        check("unexpected_xfer", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("xfer_source", 32'(bus.out_source), 32'h1);
        check("xfer_target", 32'(bus.out_target), 32'(e.target));
        check("xfer_data",   32'(bus.out_data),   32'(e.data));
        check("xfer_type",   32'(bus.out_type),   32'(e.ptype));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_target = '0; bus.req_data = '0; bus.out_ready = 1'b0;
    tick(); tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_target", 32'(bus.out_target), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_type", 32'(bus.out_type), 32'(ERR));
    check("rst_out_source", 32'(bus.out_source), 32'h1);
    check("rst_cnts", {8'(err_drop), 8'(timeout), 8'(sent_cnt), err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single destination, ready held high
    bus.out_ready = 1'b1;
    drive_req(4'b0010, 8'hA5); sb.push_back('{4'b0010, 8'hA5, SDP});
    tick(); bus.req_valid = 1'b0;
    check("sdp_valid", 32'(bus.out_valid), 32'd1);
    check("sdp_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("sdp_done_valid", 32'(bus.out_valid), 32'd0);
    check("sdp_done_ready", 32'(bus.req_ready), 32'd1);
    check("sdp_sent_cnt", 32'(sent_cnt), 32'd1);

    // overlap with own source, then empty target
    drive_req(4'b0011, 8'h11);
    tick(); bus.req_valid = 1'b0;
    check("ovl_err_drop", 32'(err_drop), 32'd1);
    check("ovl_out_valid", 32'(bus.out_valid), 32'd0);
    check("ovl_err_cnt", 32'(err_cnt), 32'd1);
    tick();
    check("ovl_drop_once", 32'(err_drop), 32'd0);
    check("ovl_no_valid", 32'(bus.out_valid), 32'd0);
    drive_req(4'b0000, 8'h22);
    tick(); bus.req_valid = 1'b0;
    check("zero_err_drop", 32'(err_drop), 32'd1);
    check("zero_err_cnt", 32'(err_cnt), 32'd2);
    tick();

    // broadcast with three stall cycles
    bus.out_ready = 1'b0;
    drive_req(4'b1111, 8'h3C); sb.push_back('{4'b1111, 8'h3C, BDP});
    tick(); bus.req_valid = 1'b0; bus.req_data = 8'hFF; bus.req_target = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      check("bdp_stall_valid", 32'(bus.out_valid), 32'd1);
      check("bdp_stall_fields", {20'd0, bus.out_target, bus.out_data},
            {20'd0, 4'b1111, 8'h3C});
      check("bdp_stall_type", 32'(bus.out_type), 32'(BDP));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bdp_sent_cnt", 32'(sent_cnt), 32'd2);
    check("bdp_done_valid", 32'(bus.out_valid), 32'd0);

    // stall timeout on an MDP packet
    bus.out_ready = 1'b0;
    drive_req(4'b0110, 8'h5A);
    tick(); bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("to_valid_high", 32'(bus.out_valid), 32'd1);
      check("to_no_pulse_yet", 32'(timeout), 32'd0);
      tick();
    end
    check("to_valid_low", 32'(bus.out_valid), 32'd0);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_req_ready", 32'(bus.req_ready), 32'd1);
    check("to_sent_cnt", 32'(sent_cnt), 32'd2);
    check("to_err_cnt", 32'(err_cnt), 32'd3);
    tick();
    check("to_pulse_once", 32'(timeout), 32'd0);

    // ready arriving in the 8th stall cycle wins
    drive_req(4'b0110, 8'h77); sb.push_back('{4'b0110, 8'h77, MDP});
    tick(); bus.req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("late_still_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("late_no_timeout", 32'(timeout), 32'd0);
    check("late_sent_cnt", 32'(sent_cnt), 32'd3);
    check("late_err_cnt", 32'(err_cnt), 32'd3);
    tick();
    check("late_no_timeout2", 32'(timeout), 32'd0);

    // sent_cnt wrap
    force dut.sent_cnt = 16'hFFFF;
    #1;
    release dut.sent_cnt;
    drive_req(4'b1000, 8'hC3); sb.push_back('{4'b1000, 8'hC3, SDP});
    tick(); bus.req_valid = 1'b0;
    tick();
    check("wrap_sent_cnt", 32'(sent_cnt), 32'd0);

    // err_cnt saturation
    drive_req(4'b0000, 8'h00);
    for (int i = 0; i < 260; i++) tick();
    bus.req_valid = 1'b0;
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);
    check("sat_drop_pulse", 32'(err_drop), 32'd1);
    tick();
    check("sat_hold", 32'(err_cnt), 32'hFF);

    // reset while sending
    bus.out_ready = 1'b0;
    drive_req(4'b1010, 8'h99);
    tick(); bus.req_valid = 1'b0;
    check("rs_in_send", 32'(bus.out_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rs_out_valid", 32'(bus.out_valid), 32'd0);
    check("rs_req_ready", 32'(bus.req_ready), 32'd1);
    check("rs_cnts", {8'd0, 8'(sent_cnt), err_cnt, 8'd0}, 32'd0);
    check("rs_sent_hi", 32'(sent_cnt), 32'd0);
    check("rs_no_timeout", 32'(timeout), 32'd0);
    check("rs_out_type", 32'(bus.out_type), 32'(ERR));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rs_quiet", {30'd0, timeout, bus.out_valid}, 32'd0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("xfer_count", 32'(n_xfer), 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/packet_tx.md
# packet_tx

Ingress-side packet transmitter for one port of the 4-port switch. Accepts a send request from the port's host (target mask plus payload), stamps the port's own one-hot source address, and classifies and validates the packet with the same rules the switch parser applies. Valid packets go out on the switch ingress valid/ready interface; invalid ones are dropped locally. A stall timeout keeps a dead switch port from hanging the host.

## Interface
- PORT_ID, 0: this port's index (0..3); out_source = 1 << PORT_ID
- TIMEOUT, 16: cycles out_valid may stall without out_ready before abort (≥2)
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  1  host request present
- req_ready  output  1  block can accept a request
- req_target  input  ADDR_WIDTH  destination port mask
- req_data  input  DATA_WIDTH  payload
- out_valid  output  1  packet presented to switch ingress
- out_ready  input  1  switch accepts packet
- out_source  output  ADDR_WIDTH  one-hot source
- out_target  output  ADDR_WIDTH  destination mask
- out_data  output  DATA_WIDTH  payload
- out_type  output  p_type  SDP/MDP/BDP classification
- err_drop  output  1  one-cycle pulse: request rejected as invalid
- timeout  output  1  one-cycle pulse: send aborted on stall
- sent_cnt  output  16  packets delivered, wraps
- err_cnt  output  8  drops plus timeouts, saturates at 255

## Operation
- States: IDLE, SEND.
- IDLE: req_ready = 1. On req_valid, latch req_target/req_data and classify:
  - Target with 1 set bit is SDP, 2–3 set bits is MDP, 4 set bits is BDP, 0 set bits is ERR.
  - A request is valid when its type is not ERR, and either (target & source) == 0 or the type is BDP.
  - Valid request: go to SEND and load the out_* registers.
  - Invalid request: stay in IDLE, pulse err_drop on the next cycle, and increment err_cnt.
- SEND: req_ready = 0, out_valid = 1, and all out_* fields are held stable. A stall counter increments each cycle that out_ready = 0.
  - out_valid && out_ready: transfer. Increment sent_cnt, clear the stall counter, go to IDLE.
  - Stall counter reaches TIMEOUT-1 with out_ready = 0: abort. out_valid goes low on the next cycle, timeout pulses, err_cnt increments, and the block returns to IDLE. This is the only permitted withdrawal of out_valid.
  - If out_ready rises in the same cycle the timeout would fire, the transfer wins and there is no timeout.
- out_type is registered. out_target/out_data/out_type are don't-care while out_valid = 0, but are reset to 0/0/ERR.
- err_cnt and sent_cnt both increment by at most 1 per cycle, because the two events are exclusive.

## Timing
- Reset values (rst_n low at an edge): state IDLE, req_ready 1, out_valid 0, out_target 0, out_data 0, out_type ERR, out_source = 1 << PORT_ID (constant), err_drop 0, timeout 0, sent_cnt 0, err_cnt 0, stall counter 0.
- Reset in SEND: the packet is discarded at that edge with no timeout pulse and no counter change (counters are reset anyway).
- Acceptance at edge N puts out_valid high from cycle N+1.
- A transfer at edge M puts req_ready high in cycle M+1. Peak throughput is one packet per 2 cycles.
- err_drop is asserted in the cycle after the accepting edge. timeout is asserted in the cycle out_valid first reads 0.
- sent_cnt wraps from 16'hFFFF to 0. err_cnt holds at 8'hFF.

## Structure
- Shared in packet_pkg: ADDR_WIDTH = 4, DATA_WIDTH = 8, and p_type {SDP, MDP, BDP, ERR}. Add a typedef enum for the tx state {TX_IDLE, TX_SEND}.
- The classification/validation is a combinational function of (source, target). Instantiate the existing packet parser as the sub-module so that tx and rx rules cannot diverge. No other sub-modules.

## Test plan
- Single destination: PORT_ID = 0, req_target 4'b0010, req_data 8'hA5, out_ready held 1 → out_valid one cycle after acceptance with out_source 0001, out_target 0010, out_type SDP, out_data A5; sent_cnt = 1.
- Overlap rejected: PORT_ID = 0, req_target 4'b0011 → out_valid never asserts, err_drop pulses once, err_cnt = 1. Repeat with target 0000 → err_cnt = 2.
- Broadcast with backpressure: req_target 4'b1111, out_ready low for 3 cycles then high → type BDP (overlap allowed), out_* stable across the stall, one transfer, sent_cnt increments by 1.
- Timeout: TIMEOUT = 8, req_target 4'b0110 (MDP), out_ready held 0 → out_valid high 8 cycles then low, timeout pulses once, sent_cnt unchanged, req_ready = 1. Also: out_ready rises in the 8th stall cycle → transfer, no timeout.
- Counter limits: force sent_cnt to 16'hFFFF, then send one packet → sent_cnt = 0. Generate 260 invalid requests → err_cnt = 255.
- Reset mid-send: rst_n low for 1 cycle while in SEND → next cycle out_valid 0, req_ready 1, all counters 0, no timeout pulse.
